urom_loader: RTL and testbench
==============================

Name: urom_loader

Overview:
- Writer side of the microcode control store. Receives a byte stream (valid/ready), assembles control-store words of CONTROL_WIDTH+ADDR_WIDTH+1 bits (control field, next-address field, select bit), and writes them into a RAM-backed control store.
- That store is the one the microsequencer reads.
- Holds the sequencer in reset while a load is in progress, then reports success or checksum failure.

Parameters:
- ADDR_WIDTH, 8, control-store address width; must be ≤ 8 (address is sent as one byte).
- CONTROL_WIDTH, 21, control field width.
- WORD_WIDTH, CONTROL_WIDTH+ADDR_WIDTH+1, stored word width (derived; do not override).
- BYTES_PER_WORD, (WORD_WIDTH+7)/8, bytes per word on the stream (derived; 4 at defaults).
- SYNC_BYTE, 8'hA5, load-start marker.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid & in_ready at the clock edge.
- mem_we  out  1  control-store write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  WORD_WIDTH  write data.
- seq_hold  out  1  drive the sequencer reset; high during a load.
- busy  out  1  a load is in progress (state ≠ IDLE).
- done  out  1  last load passed its checksum; sticky.
- error  out  1  last load failed its checksum; sticky.

Behaviour:
- Reset (async): state = IDLE. All outputs 0 except in_ready = 1. Internal address, counters and checksum cleared.
- A reset asserted mid-load abandons the load. Words already written stay in the store. done and error are both 0 afterwards.
- States: IDLE → ADDR → COUNT → DATA ⇄ WRITE → CHECK → IDLE.
- IDLE: in_ready = 1. A byte equal to SYNC_BYTE → ADDR; on that transfer, clear done, error and the checksum, and set seq_hold. Any other byte is consumed and discarded.
- ADDR: accepted byte → base address = byte[ADDR_WIDTH-1:0]; checksum += byte → COUNT.
- COUNT: accepted byte N → word count = N+1 (1..256); checksum += byte → DATA; byte index = 0.
- DATA: bytes are assembled LSB first. Byte k fills word bits [8k+7:8k]. Bits above WORD_WIDTH-1 in the last byte are ignored but still added to the checksum. Every data byte adds to the checksum. After byte BYTES_PER_WORD-1 is accepted → WRITE.
- WRITE: exactly one cycle.
  - in_ready = 0, mem_we = 1, mem_addr = current address, mem_wdata = assembled word.
  - Address then increments modulo 2^ADDR_WIDTH (wraps from 2^ADDR_WIDTH-1 to 0).
  - Remaining count decrements; if it reaches 0 → CHECK, else → DATA.
- mem_addr and mem_wdata are registered and valid only while mem_we = 1. Their value at other times is don't-care, but they hold their last value.
- CHECK: accepted byte compared with checksum (8-bit sum mod 256 of address, count and data bytes; sync excluded). Match → done = 1; mismatch → error = 1. Either way → IDLE, and seq_hold/busy drop on the same edge.
- Throughput: one byte per cycle in ADDR/COUNT/DATA/CHECK; one bubble cycle per word (WRITE).
- in_ready depends on state only, never combinationally on in_valid.
- A SYNC_BYTE received outside IDLE is ordinary data; there is no resync mid-load.
- in_valid low stalls every state except WRITE indefinitely; no timeout.
- done and error are never high together.

Decomposition:
- Shared package/include (urom_pkg): state encodings (IDLE, ADDR, COUNT, DATA, WRITE, CHECK), SYNC_BYTE default, BYTES_PER_WORD derivation.
- One natural sub-module: urom_word_packer. It shifts bytes into a WORD_WIDTH register, tracks the byte index, and flags word-complete. The FSM, address counter and checksum stay in urom_loader.
- The existing register module can hold the address counter.

Test Plan:
- Single word, good checksum: A5,10,00,01,02,03,04,1A →
  - one mem_we pulse, addr 0x10, wdata 0x04030201;
  - done = 1, error = 0;
  - seq_hold high from the cycle after A5 until the cycle after 1A.
- Bad checksum: A5,10,00,01,02,03,04,1B → same write occurs; error = 1, done = 0; a following good load clears error and sets done.
- Address wrap: A5,FF,01, word0 = 11,22,33,44, word1 = 55,66,77,08, correct checksum →
  - writes at FF then 00;
  - word1 wdata = 0x08776655 (the 0x08 byte fits within 30 bits);
  - top-bit truncation checked with last byte FF → wdata[29:24] = 0x3F.
- Garbage and stalls: bytes 00,FF,5A in IDLE are ignored (busy stays 0). Then a load with in_valid toggled every cycle → identical writes, in_ready = 0 exactly in WRITE cycles.
- Full store: count 0xFF → 256 mem_we pulses at addresses 0x00..0xFF in order with correct data; done = 1.
- Reset mid-load: assert reset after the second data byte → outputs return to reset values immediately (asynchronous). A fresh load then completes normally.

Source files
------------

// File: rtl/urom_pkg.sv
// Shared definitions for the microcode control-store loader: FSM state
// encodings, the default load-start marker and word/byte helpers.
package urom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHECK = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Number of stream bytes needed to carry one stored word.
  function automatic int bytes_per_word(input int word_width);
    return (word_width + 7) / 8;
  endfunction

  // Running 8-bit checksum: plain sum modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/urom_word_packer.sv
// Assembles stream bytes (least significant byte first) into one control-store
// word. Only the first BYTES_PER_WORD-1 bytes are stored; the final byte is
// merged combinationally so the complete word is available on the very edge
// that accepts it. Needs a word of at least two bytes.
module urom_word_packer
  import urom_pkg::*;
#(
  parameter int WORD_WIDTH = 30
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [7:0]            data,
  output logic [WORD_WIDTH-1:0] word_next,
  output logic                  complete
);

  localparam int BPW      = bytes_per_word(WORD_WIDTH);
  localparam int LOW_BITS = (BPW - 1) * 8;
  localparam int TOP_BITS = WORD_WIDTH - LOW_BITS;
  localparam int IDX_W    = (BPW > 1) ? $clog2(BPW) : 1;

  logic [LOW_BITS-1:0] low;
  logic [LOW_BITS-1:0] low_shift;
  logic [IDX_W-1:0]    index;

  // New bytes enter at the top and move down, so byte 0 ends up in bits [7:0].
  generate
    if (LOW_BITS > 8) begin : g_shift
      assign low_shift = {data, low[LOW_BITS-1:8]};
    end else begin : g_single
      assign low_shift = data;
    end
  endgenerate

  // Last byte: bits above WORD_WIDTH-1 are dropped here.
  assign word_next = {data[TOP_BITS-1:0], low};
  assign complete  = load && (index == IDX_W'(BPW - 1));

  // Byte shift register and byte index; index restarts after each full word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      low   <= '0;
      index <= '0;
    end else if (clear) begin
      index <= '0;
    end else if (load) begin
      low   <= low_shift;
      index <= complete ? '0 : (index + IDX_W'(1));
    end else begin
      index <= index;
    end
  end

endmodule

// File: rtl/urom_loader.sv
// Writer side of the microcode control store: receives a framed byte stream
// (sync, address, count, data words, checksum), writes each word into the
// store, holds the sequencer in reset during the load and reports the result.
module urom_loader
  import urom_pkg::*;
#(
  parameter int         ADDR_WIDTH    = 8,
  parameter int         CONTROL_WIDTH = 21,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  localparam int        WORD_WIDTH    = CONTROL_WIDTH + ADDR_WIDTH + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  seq_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [8:0]            remaining;
  logic [7:0]            csum;
  logic                  accept;
  logic                  is_sync;
  logic [WORD_WIDTH-1:0] word_next;
  logic                  word_complete;

  assign accept  = in_valid && in_ready;
  assign is_sync = (in_data == SYNC_BYTE);

  urom_word_packer #(.WORD_WIDTH(WORD_WIDTH)) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     ((state == ST_COUNT) && accept),
    .load      ((state == ST_DATA) && accept),
    .data      (in_data),
    .word_next (word_next),
    .complete  (word_complete)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; WRITE never waits on the stream.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept && is_sync) next_state = ST_ADDR;  else next_state = ST_IDLE;
      ST_ADDR:  if (accept)            next_state = ST_COUNT; else next_state = ST_ADDR;
      ST_COUNT: if (accept)            next_state = ST_DATA;  else next_state = ST_COUNT;
      ST_DATA:  if (word_complete)     next_state = ST_WRITE; else next_state = ST_DATA;
      ST_WRITE: if (remaining == 9'd1) next_state = ST_CHECK; else next_state = ST_DATA;
      ST_CHECK: if (accept)            next_state = ST_IDLE;  else next_state = ST_CHECK;
      default:                         next_state = ST_IDLE;
    endcase
  end

  // Outputs registered from the next state so they line up with the state itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      seq_hold <= 1'b0;
    end else begin
      in_ready <= (next_state != ST_WRITE);
      mem_we   <= (next_state == ST_WRITE);
      busy     <= (next_state != ST_IDLE);
      seq_hold <= (next_state != ST_IDLE);
    end
  end

  // Address counter, word count, checksum, write port and sticky status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      remaining <= 9'd0;
      csum      <= 8'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && is_sync) begin
            done  <= 1'b0;
            error <= 1'b0;
            csum  <= 8'd0;
          end
        end
        ST_ADDR: begin
          if (accept) begin
            addr <= in_data[ADDR_WIDTH-1:0];
            csum <= csum_add(csum, in_data);
          end
        end
        ST_COUNT: begin
          if (accept) begin
            remaining <= {1'b0, in_data} + 9'd1;
            csum      <= csum_add(csum, in_data);
          end
        end
        ST_DATA: begin
          if (accept) begin
            csum <= csum_add(csum, in_data);
          end
          if (word_complete) begin
            mem_addr  <= addr;
            mem_wdata <= word_next;
          end
        end
        ST_WRITE: begin
          addr      <= addr + ADDR_WIDTH'(1);
          remaining <= remaining - 9'd1;
        end
        ST_CHECK: begin
          if (accept) begin
            if (in_data == csum) begin
              done <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: begin
          addr <= addr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urom_loader.sv
// Scoreboard bench for urom_loader: stimulus pushes expected writes and load
// results into queues, a negedge monitor pops and compares them.
module tb_urom_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [29:0] data;
  } wr_t;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [29:0] mem_wdata;
  logic        seq_hold;
  logic        busy;
  logic        done;
  logic        error;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          toggle   = 1'b0;
  bit          prev_busy = 1'b0;
  wr_t         exp_wr[$];
  logic [1:0]  exp_st[$];

  urom_loader dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .seq_hold  (seq_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was transferred.
  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    if (toggle) begin
      in_valid = 1'b0;
      @(negedge clock);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) begin
      check("send_timeout", 64'(guard), 64'd0);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [29:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  // Monitor: compares every write pulse and every end-of-load status.
  always @(negedge clock) begin
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      check("ready_vs_write", {62'd0, in_ready, mem_we}, {62'd0, ~mem_we, mem_we});
      check("hold_vs_busy", {63'd0, seq_hold}, {63'd0, busy});
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", {56'd0, mem_addr}, 64'hFFFF);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_addr", {56'd0, mem_addr}, {56'd0, w.addr});
          check("wr_data", {34'd0, mem_wdata}, {34'd0, w.data});
        end
      end
      if (prev_busy && !busy) begin
        if (exp_st.size() == 0) begin
          check("unexpected_end", {62'd0, done, error}, 64'hFF);
        end else begin
          check("status", {62'd0, done, error}, {62'd0, exp_st.pop_front()});
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] cs;
    logic [7:0] b0, b1, b2, b3;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_outputs", {59'd0, mem_we, seq_hold, busy, done, error}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single word, good checksum.
    push_wr(8'h10, 30'h04030201);
    exp_st.push_back(2'b10);
    send(8'hA5);
    check("t1_hold_after_sync", {62'd0, seq_hold, busy}, 64'd3);
    q = '{8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_seq(q);
    check("t1_hold_before_csum", {63'd0, seq_hold}, 64'd1);
    send(8'h1A);
    check("t1_hold_after_csum", {62'd0, seq_hold, busy}, 64'd0);
    check("t1_done_error", {62'd0, done, error}, 64'd2);

    // Bad checksum, then a good load clears error.
    push_wr(8'h10, 30'h04030201);
    exp_st.push_back(2'b01);
    q = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h1B};
    send_seq(q);
    check("t2_error", {62'd0, done, error}, 64'd1);
    push_wr(8'h10, 30'h04030201);
    exp_st.push_back(2'b10);
    q = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h1A};
    send_seq(q);
    check("t2_recover", {62'd0, done, error}, 64'd2);

    // Address wrap FF -> 00, checksum E4.
    push_wr(8'hFF, 30'h04332211);
    push_wr(8'h00, 30'h08776655);
    exp_st.push_back(2'b10);
    q = '{8'hA5, 8'hFF, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h08, 8'hE4};
    send_seq(q);

    // Top-bit truncation: last byte FF keeps only 6 bits; checksum 50.
    push_wr(8'h20, 30'h3FCCBBAA);
    exp_st.push_back(2'b10);
    q = '{8'hA5, 8'h20, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hFF, 8'h50};
    send_seq(q);

    // Garbage in IDLE is discarded.
    q = '{8'h00, 8'hFF, 8'h5A};
    foreach (q[i]) begin
      send(q[i]);
      check("t4_garbage_busy", {63'd0, busy}, 64'd0);
    end

    // Same load with in_valid toggling every cycle.
    toggle = 1'b1;
    push_wr(8'h10, 30'h04030201);
    exp_st.push_back(2'b10);
    q = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h1A};
    send_seq(q);
    toggle = 1'b0;

    // Full store: 256 words at 00..FF.
    q = '{8'hA5, 8'h00, 8'hFF};
    cs = 8'h00 + 8'hFF;
    for (int i = 0; i < 256; i++) begin
      b0 = 8'(i);
      b1 = b0 ^ 8'h5A;
      b2 = ~b0;
      b3 = b0 + 8'h81;
      q.push_back(b0);
      q.push_back(b1);
      q.push_back(b2);
      q.push_back(b3);
      cs = cs + b0 + b1 + b2 + b3;
      push_wr(b0, {b3[5:0], b2, b1, b0});
    end
    q.push_back(cs);
    exp_st.push_back(2'b10);
    send_seq(q);
    check("t5_done", {62'd0, done, error}, 64'd2);

    // Reset mid-load after the second data byte.
    q = '{8'hA5, 8'h30, 8'h00, 8'h01, 8'h02};
    send_seq(q);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("t6_rst_outputs", {59'd0, mem_we, seq_hold, busy, done, error}, 64'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    push_wr(8'h40, 30'h2FBEADDE);
    exp_st.push_back(2'b10);
    q = '{8'hA5, 8'h40, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h78};
    send_seq(q);
    check("t6_done", {62'd0, done, error}, 64'd2);

    repeat (5) @(negedge clock);
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    check("st_queue_empty", 64'(exp_st.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
